hilo_muldiv_unit: RTL and testbench
===================================

// Module: hilo_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the single-cycle MIPS core.
//  Consumes the register-file read ports (RD1 = rs value, RD2 = rt value) when decode issues MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Owns HI/LO, exposes them for MFHI/MFLO writeback, and raises busy so the core stalls PC while an operation runs.
// PARAMETERS
//  WIDTH     32   operand width; HI and LO are each WIDTH bits
//  CNT_W     6    iteration counter width; must hold WIDTH (derived: $clog2(WIDTH)+1)
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      issue request; sampled only in IDLE
//  op        in   3      operation code (encodings in package)
//  rs_val    in   WIDTH  operand A (dividend / multiplicand / MTHI/MTLO source)
//  rt_val    in   WIDTH  operand B (divisor / multiplier)
//  flush     in   1      cancel in-flight operation
//  busy      out  1      high while state != IDLE; core stalls when busy
//  done      out  1      one-cycle pulse: HI/LO updated by MULT/DIV on this edge
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  Clocking: one clock clk; reset rst_n asynchronous, active-low.
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//  FSM IDLE -> RUN -> FIX -> IDLE.
//  IDLE + start + op=MTHI/MTLO: hi (or lo) <= rs_val on that edge; stays IDLE; no busy, no done.
//  IDLE + start + mul/div op: operands latched; signed ops store magnitudes + result signs; -> RUN, counter=0.
//  RUN: one shift-add (mul) or restoring shift-subtract (div) step per cycle; exactly WIDTH cycles; counter==WIDTH-1 -> FIX.
//  FIX: sign correction applied; hi/lo written; done=1 for exactly the following cycle; -> IDLE.
//  Latency: start sampled at edge E0; busy high E0+1 .. E0+WIDTH+1; hi/lo new value and done visible after edge E0+WIDTH+1 (33 cycles at WIDTH=32).
//  hi/lo hold their previous values throughout RUN; only FIX or MTHI/MTLO modify them.
//  MULT/MULTU: {hi,lo} = 2*WIDTH-bit product; MULT signed two's complement, MULTU unsigned.
//  DIV/DIVU: lo = quotient, hi = remainder; signed: quotient truncates toward zero; remainder takes dividend sign.
//  Divide by zero (rt_val=0): no trap; hi = rs_val, lo = all ones; normal 33-cycle timing.
//  DIV overflow (rs=0x80000000, rt=0xFFFFFFFF): lo = 0x80000000, hi = 0.
//  start while busy: ignored (no queuing); decode must hold start until busy is low.
//  flush in RUN or FIX: -> IDLE next edge; hi/lo unchanged; done not asserted. flush with start in IDLE: flush wins, nothing issued.
//  Undefined op with start: ignored, stays IDLE.
//  rst_n assertion mid-operation: immediate return to reset values, including hi/lo.
// STRUCTURE
//  Package muldiv_pkg: op encodings (OP_MULT=0, OP_MULTU=1, OP_DIV=2, OP_DIVU=3, OP_MTHI=4, OP_MTLO=5); FSM state typedef; WIDTH default.
//  One sub-module muldiv_step: combinational single-iteration datapath (add/shift or subtract/shift), shared by mul and div.
//  FSM, counter, sign bookkeeping, and hi/lo registers in the top module.
// TESTING
//  MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001; done for 1 cycle; busy for 33 cycles.
//  MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIVU 100/0 -> hi=100, lo=0xFFFFFFFF; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi/lo updated on the next edge each; busy never high, done never pulses.
//  Start DIVU; second start at cycle 5 -> ignored. flush at cycle 10 -> IDLE next edge; hi/lo unchanged; no done.
//  Drop rst_n mid-RUN (cycle 20) -> busy, done, hi, lo read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: operation codes,
// FSM states and small op-decode helpers.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  function automatic logic op_is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative datapath: shift-add for multiply, restoring
// shift-subtract for divide. Operates purely on unsigned magnitudes.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, opnd} : '0);
    shifted = {acc, q[WIDTH-1]};
    borrow  = shifted < {1'b0, opnd};
    // When no borrow the true difference is below the divisor, so WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_next = borrow ? shifted[WIDTH-1:0] : diff;
      q_next   = {q[WIDTH-2:0], ~borrow};
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers;
// busy stalls the core while an operation iterates.
module hilo_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] acc, q, opnd;
  logic [WIDTH-1:0] acc_next, q_next;
  logic             is_div, sign_q, sign_r, div_zero;
  logic             issue_md;

  logic signed [2*WIDTH-1:0] prod_fix;
  logic signed [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]          fix_hi, fix_lo;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic is_signed);
    logic signed [WIDTH-1:0] xs;
    xs = $signed(x);
    return (is_signed && xs < 0) ? -xs : xs;
  endfunction

  function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m, input logic neg);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  function automatic logic signed [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] m,
                                                                input logic neg);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  assign issue_md = (state == ST_IDLE) && start && !flush && op_is_muldiv(op);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .q        (q),
    .opnd     (opnd),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // Issue: latch magnitudes and result signs; q holds multiplier or dividend.
  always_ff @(posedge clk) begin
    if (issue_md) begin
      is_div   <= op_is_div(op);
      sign_q   <= op_is_signed(op) && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
      sign_r   <= op_is_signed(op) && rs_val[WIDTH-1];
      div_zero <= op_is_div(op) && (rt_val == '0);
      acc      <= '0;
      q        <= op_is_div(op) ? magnitude(rs_val, op_is_signed(op)) : magnitude(rt_val, op_is_signed(op));
      opnd     <= op_is_div(op) ? magnitude(rt_val, op_is_signed(op)) : magnitude(rs_val, op_is_signed(op));
    end else if (state == ST_RUN) begin
      acc <= acc_next;
      q   <= q_next;
    end
  end

  // Fix-up: restore signs; a zero divisor forces an all-ones quotient.
  always_comb begin
    prod_fix = apply_sign_wide({acc, q}, sign_q);
    quo_fix  = apply_sign(q, sign_q);
    rem_fix  = apply_sign(acc, sign_r);
    if (is_div) begin
      fix_hi = rem_fix;
      fix_lo = div_zero ? '1 : quo_fix;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            case (op)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                state <= ST_RUN;
                count <= '0;
                busy  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (count == CNT_W'(WIDTH - 1)) begin
            state <= ST_FIX;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        ST_FIX: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit with hand-computed HI/LO results,
// latency, busy length, flush, ignored starts and asynchronous reset.
module tb_hilo_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  hilo_muldiv_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int cyc;
    int busy_cnt;
    bit got;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    tick();
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    cyc = 0;
    got = 0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 16) begin
        chk({tag, "_hold_hi"}, hi, m_hi);
        chk({tag, "_hold_lo"}, lo, m_lo);
      end
      if (done) got = 1;
      else if (busy) busy_cnt++;
    end
    chk({tag, "_latency"}, cyc, 33);
    chk({tag, "_busy_len"}, busy_cnt, 33);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    m_hi = exp_hi;
    m_lo = exp_lo;
    tick();
    chk({tag, "_done_1cyc"}, done, 1'b0);
  endtask

  initial begin
    int pulses;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst_n = 1'b1;
    tick();

    run_md("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_md("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("mult_minsq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_md("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md("divu_zero", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_md("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_md("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF);

    // MTHI / MTLO: single edge, no busy, no done.
    start = 1'b1; op = OP_MTHI; rs_val = 32'h1234_5678;
    tick();
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", busy, 1'b0);
    chk("mthi_done", done, 1'b0);
    op = OP_MTLO; rs_val = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi_kept", hi, 32'h1234_5678);
    chk("mtlo_busy", busy, 1'b0);
    chk("mtlo_done", done, 1'b0);
    m_hi = 32'h1234_5678;
    m_lo = 32'h9ABC_DEF0;

    // Undefined op is ignored.
    start = 1'b1; op = 3'd6; rs_val = 32'hAAAA_5555; rt_val = 32'd3;
    tick();
    start = 1'b0;
    chk("undef_busy", busy, 1'b0);
    chk("undef_hi", hi, m_hi);

    // flush wins over start in IDLE, for both issue classes.
    start = 1'b1; flush = 1'b1; op = OP_MULTU; rs_val = 32'd5; rt_val = 32'd6;
    tick();
    chk("flush_idle_busy", busy, 1'b0);
    op = OP_MTHI; rs_val = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_idle_mthi", hi, m_hi);

    // DIVU with an ignored second start at cycle 5 and a flush at cycle 10.
    start = 1'b1; op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd7;
    tick();
    start = 1'b0;
    chk("flushrun_busy", busy, 1'b1);
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) begin
        start = 1'b1; op = OP_MTHI; rs_val = 32'hCAFE_F00D;
      end
      if (c == 6) start = 1'b0;
      if (c == 10) flush = 1'b1;
      tick();
    end
    flush = 1'b0;
    chk("flushrun_idle", busy, 1'b0);
    chk("flushrun_hi", hi, m_hi);
    chk("flushrun_lo", lo, m_lo);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      tick();
    end
    chk("flushrun_nodone", pulses, 0);

    // Asynchronous reset mid-RUN.
    start = 1'b1; op = OP_MULTU; rs_val = 32'd12345; rt_val = 32'd678;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 20; c++) tick();
    chk("midrun_busy_pre", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("arst_stay_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
